alu_issue_ctrl: RTL and testbench
=================================

# alu_issue_ctrl

Sequencing front-end for the 4-bit `Decode_And_Execute` ALU. It accepts 9-bit register-to-register instructions over a valid/ready handshake and holds a 4-entry × 4-bit register file. For each instruction it reads both operands and drives `rs`, `rt` and `sel` into the ALU. It then captures the ALU's `rd` result and writes it back to the register file. A host write port preloads registers. The ALU is instantiated beside this block at the next level up, not inside it.

## Interface
Parameters:
- `DATA_W`, 4: operand/result width; must match the ALU.
- `REG_N`, 4: register count; `ADDR_W` = log2(`REG_N`) = 2.

Ports:
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `instr_valid`  in  1  instruction offered.
- `instr_ready`  out  1  block can accept an instruction this cycle.
- `instr`  in  9  fields `{op[8:6], dst[5:4], src1[3:2], src2[1:0]}`.
- `host_we`  in  1  host register write request.
- `host_addr`  in  2  host write address.
- `host_data`  in  4  host write data.
- `exe_rs`  out  4  ALU operand `rs`, equal to `R[src1]`.
- `exe_rt`  out  4  ALU operand `rt`, equal to `R[src2]`.
- `exe_sel`  out  3  ALU opcode; `op` passed through unchanged.
- `exe_rd`  in  4  combinational ALU result.
- `done`  out  1  one-cycle pulse on writeback.
- `result`  out  4  written value; valid while `done` = 1 and held afterwards.

## Operation
- FSM has three states: `IDLE` → `EXEC` → `WB` → `IDLE`.
- `IDLE`:
  - `instr_ready` = `~host_we`.
  - When `host_we` = 1: `R[host_addr] <= host_data`.
  - When `instr_valid & instr_ready`: latch `op` and `dst`, latch `R[src1]` into the rs register and `R[src2]` into the rt register, then go to `EXEC`.
- `EXEC`:
  - `exe_*` outputs are driven from the latched registers and stay stable for the whole cycle.
  - At the end of the cycle: `result <= exe_rd`, then go to `WB`.
- `WB`:
  - `done` = 1.
  - `R[dst] <= result` at the end of the cycle, then go to `IDLE`.
- `host_we` outside `IDLE` is ignored; the write is lost and no error is flagged.
- `instr_ready` = 0 in `EXEC` and `WB`. An `instr_valid` held high is accepted on the next `IDLE` cycle.
- Operands are read at accept time, after the previous writeback has completed, so back-to-back dependent instructions see updated values. No forwarding is needed.
- `src1 == src2` and `dst == src*` are legal.
- Arithmetic is entirely inside the ALU. This block performs no width conversion: 4 bits in, 4 bits out, wrap-around is the ALU's concern.
- ALU opcode meaning:
  - `000` rs−rt
  - `001` rs+rt
  - `010` OR
  - `011` AND
  - `100` rt arithmetic >>1
  - `101` rs rotate-left
  - `110` {1,0,1,rs<rt}
  - `111` {1,1,1,rs==rt}

## Timing
- Reset (`rst` = 1 at an edge) sets:
  - state `IDLE`;
  - all `R[i]` = 0, latched operands = 0, `exe_sel` = 0;
  - `result` = 0, `done` = 0.
- The first possible accept is the cycle after `rst` deasserts.
- `rst` mid-instruction (`EXEC` or `WB`): abort with no writeback and no `done`. Reset has priority over every other event.
- Instruction accepted at edge of cycle A:
  - cycle A+1: `EXEC`;
  - cycle A+2: `WB`, `done` = 1;
  - register updated at the end of A+2;
  - `instr_ready` = 1 again in A+3.
- Throughput: one instruction per 3 cycles.
- `instr_ready` is combinational from state and `host_we`. There is no combinational path from `instr_valid` or `exe_rd` to any output.

## Structure
- Shared package `alu_issue_pkg`:
  - opcode constants `OP_SUB`…`OP_EQ`;
  - state encoding (`S_IDLE`, `S_EXEC`, `S_WB`);
  - instruction field positions;
  - `DATA_W` and `ADDR_W` defaults.
- Sub-module `reg_file_4x4`:
  - 2 combinational read ports, 1 synchronous write port, sync reset to 0;
  - write arbitration (host vs. writeback, mutually exclusive by state) lives in the controller.
- Remainder is the FSM plus operand, opcode, `dst` and `result` registers.

## Test plan
- **Add:** reset, host writes R1=5, R2=3, instr ADD R0←R1,R2 (`001_00_01_10`).
  - `exe_rs`=5 and `exe_rt`=3 in A+1;
  - `done` in A+2 with `result`=8;
  - R0 reads back 8.
- **Sub, negative result:** SUB R3←R2,R1 → `result`=4'b1110; R3=14.
- **Back-to-back dependency:** `instr_valid` held high with ADD R0←R1,R2 then OR R1←R0,R2.
  - second instruction accepted exactly 3 cycles after the first;
  - second instruction sees R0=8, giving `result`=4'b1011.
- **Host write vs. instruction:** `host_we` and `instr_valid` both high in `IDLE`.
  - `instr_ready`=0 and the host write lands;
  - the instruction is accepted the next cycle using the new value.
- **Reset mid-instruction:** `rst` pulsed during `EXEC`.
  - no `done`, `result`=0, all registers 0;
  - `instr_ready`=1 the cycle after `rst` deasserts.
- **Compares:** with R1=5, R2=3, LT R0←R2,R1 → 4'b1011; EQ R0←R1,R1 → 4'b1111; LT R0←R1,R2 → 4'b1010.

Source files
------------

// File: rtl/alu_issue_pkg.sv
// Shared definitions for the ALU issue controller: opcodes, FSM encoding,
// instruction field layout and default widths.
package alu_issue_pkg;

  localparam int DEF_DATA_W = 4;
  localparam int DEF_ADDR_W = 2;

  // Instruction layout: {op[8:6], dst[5:4], src1[3:2], src2[1:0]}
  localparam int INSTR_W  = 9;
  localparam int OP_W     = 3;
  localparam int OP_LSB   = 6;
  localparam int DST_LSB  = 4;
  localparam int SRC1_LSB = 2;
  localparam int SRC2_LSB = 0;

  localparam logic [OP_W-1:0] OP_SUB = 3'b000;
  localparam logic [OP_W-1:0] OP_ADD = 3'b001;
  localparam logic [OP_W-1:0] OP_OR  = 3'b010;
  localparam logic [OP_W-1:0] OP_AND = 3'b011;
  localparam logic [OP_W-1:0] OP_SRA = 3'b100;
  localparam logic [OP_W-1:0] OP_ROL = 3'b101;
  localparam logic [OP_W-1:0] OP_LT  = 3'b110;
  localparam logic [OP_W-1:0] OP_EQ  = 3'b111;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_WB   = 2'd2
  } state_t;

endpackage

// File: rtl/reg_file_4x4.sv
// Small register file: two combinational read ports, one synchronous write
// port, synchronous clear to zero.
module reg_file_4x4
  import alu_issue_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [ADDR_W-1:0] i_raddr_a,
  output logic [DATA_W-1:0] o_rdata_a,
  input  logic [ADDR_W-1:0] i_raddr_b,
  output logic [DATA_W-1:0] o_rdata_b
);

  localparam int REG_N = 1 << ADDR_W;

  logic [DATA_W-1:0] r_mem [REG_N];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < REG_N; i++) begin
        r_mem[i] <= '0;
      end
    end else if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata_a = r_mem[i_raddr_a];
  assign o_rdata_b = r_mem[i_raddr_b];

endmodule

// File: rtl/alu_issue_ctrl.sv
// Issue/writeback sequencer for an external 4-bit ALU: accepts one
// instruction every three cycles, drives operands, writes the result back.
module alu_issue_ctrl
  import alu_issue_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int REG_N  = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               instr_valid,
  output logic               instr_ready,
  input  logic [INSTR_W-1:0] instr,
  input  logic               host_we,
  input  logic [1:0]         host_addr,
  input  logic [DATA_W-1:0]  host_data,
  output logic [DATA_W-1:0]  exe_rs,
  output logic [DATA_W-1:0]  exe_rt,
  output logic [OP_W-1:0]    exe_sel,
  input  logic [DATA_W-1:0]  exe_rd,
  output logic               done,
  output logic [DATA_W-1:0]  result
);

  localparam int ADDR_W = $clog2(REG_N);

  state_t              r_state;
  logic [OP_W-1:0]     r_op;
  logic [ADDR_W-1:0]   r_dst;
  logic [DATA_W-1:0]   r_rs;
  logic [DATA_W-1:0]   r_rt;
  logic [DATA_W-1:0]   r_result;
  logic                r_done;

  logic                w_accept;
  logic [ADDR_W-1:0]   w_src1;
  logic [ADDR_W-1:0]   w_src2;
  logic [DATA_W-1:0]   w_rdata_a;
  logic [DATA_W-1:0]   w_rdata_b;
  logic                w_rf_we;
  logic [ADDR_W-1:0]   w_rf_waddr;
  logic [DATA_W-1:0]   w_rf_wdata;
  logic                w_in_wb;

  assign w_src1   = instr[SRC1_LSB +: ADDR_W];
  assign w_src2   = instr[SRC2_LSB +: ADDR_W];
  assign w_in_wb  = (r_state == S_WB);

  // Host writes win IDLE; writeback owns the port in WB, so they never collide.
  assign instr_ready = (r_state == S_IDLE) && !host_we;
  assign w_accept    = instr_valid && instr_ready;

  assign w_rf_we    = w_in_wb || ((r_state == S_IDLE) && host_we);
  assign w_rf_waddr = w_in_wb ? r_dst    : host_addr[ADDR_W-1:0];
  assign w_rf_wdata = w_in_wb ? r_result : host_data;

  reg_file_4x4 #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_rf (
    .clk       (clk),
    .rst       (rst),
    .i_we      (w_rf_we),
    .i_waddr   (w_rf_waddr),
    .i_wdata   (w_rf_wdata),
    .i_raddr_a (w_src1),
    .o_rdata_a (w_rdata_a),
    .i_raddr_b (w_src2),
    .o_rdata_b (w_rdata_b)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_op     <= '0;
      r_dst    <= '0;
      r_rs     <= '0;
      r_rt     <= '0;
      r_result <= '0;
      r_done   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_done <= 1'b0;
          if (w_accept) begin
            r_op    <= instr[OP_LSB +: OP_W];
            r_dst   <= instr[DST_LSB +: ADDR_W];
            r_rs    <= w_rdata_a;
            r_rt    <= w_rdata_b;
            r_state <= S_EXEC;
          end
        end
        S_EXEC: begin
          r_result <= exe_rd;
          r_done   <= 1'b1;
          r_state  <= S_WB;
        end
        S_WB: begin
          r_done  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_done  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign exe_rs  = r_rs;
  assign exe_rt  = r_rt;
  assign exe_sel = r_op;
  assign done    = r_done;
  assign result  = r_result;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed bench for alu_issue_ctrl with a behavioural ALU closing the loop.
module tb_alu_issue_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       instr_valid = 1'b0;
  logic       instr_ready;
  logic [8:0] instr = '0;
  logic       host_we = 1'b0;
  logic [1:0] host_addr = '0;
  logic [3:0] host_data = '0;
  logic [3:0] exe_rs, exe_rt, exe_rd, result;
  logic [2:0] exe_sel;
  logic       done;

  int n_checks = 0;
  int n_fail   = 0;

  alu_issue_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .instr       (instr),
    .host_we     (host_we),
    .host_addr   (host_addr),
    .host_data   (host_data),
    .exe_rs      (exe_rs),
    .exe_rt      (exe_rt),
    .exe_sel     (exe_sel),
    .exe_rd      (exe_rd),
    .done        (done),
    .result      (result)
  );

  always #5 clk = ~clk;

  // Stand-in for the Decode_And_Execute ALU
  always_comb begin
    exe_rd = '0;
    case (exe_sel)
      3'b000: exe_rd = exe_rs - exe_rt;
      3'b001: exe_rd = exe_rs + exe_rt;
      3'b010: exe_rd = exe_rs | exe_rt;
      3'b011: exe_rd = exe_rs & exe_rt;
      3'b100: exe_rd = {exe_rt[3], exe_rt[3:1]};
      3'b101: exe_rd = {exe_rs[2:0], exe_rs[3]};
      3'b110: exe_rd = {3'b101, (exe_rs < exe_rt)};
      3'b111: exe_rd = {3'b111, (exe_rs == exe_rt)};
      default: exe_rd = '0;
    endcase
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    instr_valid = 1'b0;
    host_we = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic host_write(input logic [1:0] a, input logic [3:0] d);
    host_we = 1'b1;
    host_addr = a;
    host_data = d;
    tick();
    host_we = 1'b0;
  endtask

  // Returns one time unit after the accepting edge (EXEC cycle).
  task automatic issue(input logic [8:0] ins);
    bit ok;
    ok = 1'b0;
    instr = ins;
    instr_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      #1;
      if (instr_ready) ok = 1'b1;
      @(posedge clk);
      #1;
      if (ok) break;
    end
    instr_valid = 1'b0;
    if (!ok) begin
      n_checks++;
      n_fail++;
      $display("FAIL issue_timeout: instr %b never accepted (ready=%b)", ins, instr_ready);
    end
  endtask

  // Runs an instruction to completion; res is sampled in the WB cycle.
  task automatic run(input logic [8:0] ins, output logic [3:0] res);
    issue(ins);
    tick();
    res = result;
    tick();
  endtask

  // OR Ra <- Ra,Ra returns R[a] and leaves it unchanged.
  task automatic read_reg(input logic [1:0] a, output logic [3:0] v);
    run({3'b010, a, a, a}, v);
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++;
    if (instr_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b want 1", instr_ready); end
    n_checks++;
    if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", done); end
    n_checks++;
    if (result !== 4'd0) begin n_fail++; $display("FAIL reset_result: got %h want 0", result); end
    n_checks++;
    if ({exe_sel, exe_rs, exe_rt} !== 11'd0) begin
      n_fail++; $display("FAIL reset_exe: sel=%b rs=%h rt=%h want all 0", exe_sel, exe_rs, exe_rt);
    end
  endtask

  task automatic test_add();
    logic [3:0] v;
    do_reset();
    host_write(2'd1, 4'd5);
    host_write(2'd2, 4'd3);
    issue(9'b001_00_01_10);
    n_checks++;
    if (exe_rs !== 4'd5 || exe_rt !== 4'd3 || exe_sel !== 3'b001) begin
      n_fail++; $display("FAIL add_exec_operands: rs=%h rt=%h sel=%b want 5 3 001", exe_rs, exe_rt, exe_sel);
    end
    n_checks++;
    if (done !== 1'b0 || instr_ready !== 1'b0) begin
      n_fail++; $display("FAIL add_exec_ctrl: done=%b ready=%b want 0 0", done, instr_ready);
    end
    tick();
    n_checks++;
    if (done !== 1'b1 || result !== 4'd8) begin
      n_fail++; $display("FAIL add_wb: done=%b result=%h want 1 8", done, result);
    end
    tick();
    n_checks++;
    if (done !== 1'b0 || result !== 4'd8 || instr_ready !== 1'b1) begin
      n_fail++; $display("FAIL add_after_wb: done=%b result=%h ready=%b want 0 8 1", done, result, instr_ready);
    end
    read_reg(2'd0, v);
    n_checks++;
    if (v !== 4'd8) begin n_fail++; $display("FAIL add_readback_r0: got %h want 8", v); end
  endtask

  task automatic test_sub();
    logic [3:0] v;
    // continues from test_add: R0=8 R1=5 R2=3
    issue(9'b000_11_10_01);
    host_we = 1'b1;
    host_addr = 2'd2;
    host_data = 4'hF;
    tick();
    host_we = 1'b0;
    n_checks++;
    if (done !== 1'b1 || result !== 4'b1110) begin
      n_fail++; $display("FAIL sub_wb: done=%b result=%b want 1 1110", done, result);
    end
    tick();
    read_reg(2'd3, v);
    n_checks++;
    if (v !== 4'd14) begin n_fail++; $display("FAIL sub_readback_r3: got %h want e", v); end
    read_reg(2'd2, v);
    n_checks++;
    if (v !== 4'd3) begin n_fail++; $display("FAIL host_write_outside_idle: r2=%h want 3", v); end
  endtask

  task automatic test_back_to_back();
    int k;
    logic [3:0] v;
    do_reset();
    host_write(2'd1, 4'd5);
    host_write(2'd2, 4'd3);
    instr = 9'b001_00_01_10;
    instr_valid = 1'b1;
    #1;
    n_checks++;
    if (instr_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_first_ready: got %b want 1", instr_ready); end
    tick();
    instr = 9'b010_01_00_10;
    k = -1;
    for (int i = 0; i < 8; i++) begin
      #1;
      if (i == 1) begin
        n_checks++;
        if (done !== 1'b1 || result !== 4'd8) begin
          n_fail++; $display("FAIL b2b_first_wb: done=%b result=%h want 1 8", done, result);
        end
      end
      if (instr_ready) begin
        k = i;
        break;
      end
      @(posedge clk);
      #1;
    end
    n_checks++;
    if (k !== 2) begin n_fail++; $display("FAIL b2b_accept_gap: ready after %0d EXEC/WB cycles, want 2", k); end
    tick();
    instr_valid = 1'b0;
    n_checks++;
    if (exe_rs !== 4'd8 || exe_rt !== 4'd3) begin
      n_fail++; $display("FAIL b2b_second_operands: rs=%h rt=%h want 8 3", exe_rs, exe_rt);
    end
    tick();
    n_checks++;
    if (done !== 1'b1 || result !== 4'b1011) begin
      n_fail++; $display("FAIL b2b_second_wb: done=%b result=%b want 1 1011", done, result);
    end
    tick();
    read_reg(2'd1, v);
    n_checks++;
    if (v !== 4'd11) begin n_fail++; $display("FAIL b2b_readback_r1: got %h want b", v); end
  endtask

  task automatic test_host_vs_instr();
    do_reset();
    host_write(2'd1, 4'd5);
    host_we = 1'b1;
    host_addr = 2'd2;
    host_data = 4'd6;
    instr = 9'b001_00_01_10;
    instr_valid = 1'b1;
    #1;
    n_checks++;
    if (instr_ready !== 1'b0) begin n_fail++; $display("FAIL hvi_ready_low: got %b want 0", instr_ready); end
    tick();
    host_we = 1'b0;
    #1;
    n_checks++;
    if (instr_ready !== 1'b1) begin n_fail++; $display("FAIL hvi_ready_next: got %b want 1", instr_ready); end
    tick();
    instr_valid = 1'b0;
    n_checks++;
    if (exe_rs !== 4'd5 || exe_rt !== 4'd6) begin
      n_fail++; $display("FAIL hvi_operands: rs=%h rt=%h want 5 6", exe_rs, exe_rt);
    end
    tick();
    n_checks++;
    if (done !== 1'b1 || result !== 4'd11) begin
      n_fail++; $display("FAIL hvi_wb: done=%b result=%h want 1 b", done, result);
    end
    tick();
  endtask

  task automatic test_reset_mid();
    logic [3:0] v;
    logic [3:0] acc;
    do_reset();
    host_write(2'd1, 4'd5);
    host_write(2'd2, 4'd3);
    issue(9'b001_00_01_10);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    n_checks++;
    if (done !== 1'b0 || result !== 4'd0 || instr_ready !== 1'b1) begin
      n_fail++; $display("FAIL rstmid_state: done=%b result=%h ready=%b want 0 0 1", done, result, instr_ready);
    end
    tick();
    n_checks++;
    if (done !== 1'b0) begin n_fail++; $display("FAIL rstmid_no_done: got %b want 0", done); end
    acc = '0;
    for (int a = 0; a < 4; a++) begin
      read_reg(a[1:0], v);
      acc = acc | v;
    end
    n_checks++;
    if (acc !== 4'd0) begin n_fail++; $display("FAIL rstmid_regs_cleared: OR of R0..R3=%h want 0", acc); end
  endtask

  task automatic test_compares();
    logic [3:0] v;
    do_reset();
    host_write(2'd1, 4'd5);
    host_write(2'd2, 4'd3);
    run(9'b110_00_10_01, v);
    n_checks++;
    if (v !== 4'b1011) begin n_fail++; $display("FAIL lt_r2_r1: got %b want 1011", v); end
    run(9'b111_00_01_01, v);
    n_checks++;
    if (v !== 4'b1111) begin n_fail++; $display("FAIL eq_r1_r1: got %b want 1111", v); end
    run(9'b110_00_01_10, v);
    n_checks++;
    if (v !== 4'b1010) begin n_fail++; $display("FAIL lt_r1_r2: got %b want 1010", v); end
    read_reg(2'd0, v);
    n_checks++;
    if (v !== 4'b1010) begin n_fail++; $display("FAIL cmp_readback_r0: got %b want 1010", v); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_add();
    test_sub();
    test_back_to_back();
    test_host_vs_instr();
    test_reset_mid();
    test_compares();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
